// File: rtl/yolo_stream_loader.sv
// yolo_stream_loader: AXI4-Stream load front end. Splits one MM2S load packet
// into 12 fixed-size sections, keeps a word count and 32-bit checksum for each
// section, then returns a 13-word S2MM report (12 digests plus a status word).
module yolo_stream_loader #(
  parameter int TBITS = 64,
  parameter int TBYTE = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             S_AXIS_MM2S_ACLK,
  input  logic             M_AXIS_S2MM_ACLK,
  input  logic             S_AXIS_MM2S_TVALID,
  output logic             S_AXIS_MM2S_TREADY,
  input  logic [TBITS-1:0] S_AXIS_MM2S_TDATA,
  input  logic [TBYTE-1:0] S_AXIS_MM2S_TKEEP,
  input  logic             S_AXIS_MM2S_TLAST,
  output logic             M_AXIS_S2MM_TVALID,
  input  logic             M_AXIS_S2MM_TREADY,
  output logic [TBITS-1:0] M_AXIS_S2MM_TDATA,
  output logic [TBYTE-1:0] M_AXIS_S2MM_TKEEP,
  output logic             M_AXIS_S2MM_TLAST
);

  localparam int          NSEC        = 12;
  localparam logic [31:0] TOTAL_WORDS = 32'd24649;
  localparam logic [3:0]  LAST_RPT    = 4'd12;

  typedef enum logic {LOAD, REPORT} state_t;

  // Section sizes in 64-bit words, in packet order.
  function automatic logic [23:0] sec_size(input logic [3:0] idx);
    case (idx)
      4'd0:    sec_size = 24'd384;
      4'd1:    sec_size = 24'd5;
      4'd2:    sec_size = 24'd32;
      4'd3:    sec_size = 24'd480;
      4'd4:    sec_size = 24'd32;
      4'd5:    sec_size = 24'd5120;
      4'd6:    sec_size = 24'd64;
      4'd7:    sec_size = 24'd10240;
      4'd8:    sec_size = 24'd64;
      4'd9:    sec_size = 24'd8192;
      4'd10:   sec_size = 24'd4;
      4'd11:   sec_size = 24'd32;
      default: sec_size = 24'd0;
    endcase
  endfunction

  // The per-port stream clocks are the same net as aclk; kept only for the port map.
  logic unused_clk;
  assign unused_clk = S_AXIS_MM2S_ACLK ^ M_AXIS_S2MM_ACLK;

  state_t      state_reg, state_next;
  logic        tready_reg;
  logic [3:0]  sec_idx_reg;
  logic [3:0]  rpt_idx_reg;
  logic [31:0] total_reg;
  logic        overflow_reg;
  logic        early_reg;

  logic [TBITS-1:0]          masked_data;
  logic [31:0]               word_contrib;
  logic [NSEC-1:0][23:0]     cnt_vec;
  logic [NSEC-1:0][31:0]     sum_vec;
  logic                      s_fire;
  logic                      accept_word;
  logic                      sec_done;
  logic                      last_rpt;
  logic                      clear_all;
  logic                      m_tvalid;
  logic [TBITS-1:0]          rpt_data;

  // Zero disabled byte lanes before they enter the checksum.
  genvar gi;
  generate
    for (gi = 0; gi < TBYTE; gi++) begin : g_keep
      assign masked_data[gi*8 +: 8] = S_AXIS_MM2S_TKEEP[gi] ? S_AXIS_MM2S_TDATA[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign word_contrib = masked_data[63:32] + masked_data[31:0];
  assign s_fire       = S_AXIS_MM2S_TVALID & tready_reg;
  // Words past the full image/weight set are counted in the total but never summed.
  assign accept_word  = s_fire && (total_reg < TOTAL_WORDS);
  assign sec_done     = (cnt_vec[sec_idx_reg] + 24'd1) == sec_size(sec_idx_reg);
  assign last_rpt     = (rpt_idx_reg == LAST_RPT);
  assign clear_all    = (state_reg == REPORT) && M_AXIS_S2MM_TREADY && last_rpt;

  // Per-section word counter and checksum; only the active section updates.
  generate
    for (gi = 0; gi < NSEC; gi++) begin : g_sec
      logic [23:0] cnt_reg;
      logic [31:0] sum_reg;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_reg <= '0;
          sum_reg <= '0;
        end else if (clear_all) begin
          cnt_reg <= '0;
          sum_reg <= '0;
        end else if (accept_word && (sec_idx_reg == 4'(gi))) begin
          cnt_reg <= cnt_reg + 24'd1;
          sum_reg <= sum_reg + word_contrib;
        end
      end
      assign cnt_vec[gi] = cnt_reg;
      assign sum_vec[gi] = sum_reg;
    end
  endgenerate

  // State register; input ready is registered so it rises on the first edge after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg  <= LOAD;
      tready_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tready_reg <= (state_next == LOAD);
    end
  end

  // Next state: LOAD until the TLAST transfer, REPORT until word 12 is taken.
  always_comb begin
    state_next = state_reg;
    m_tvalid   = 1'b0;
    case (state_reg)
      LOAD: begin
        if (s_fire && S_AXIS_MM2S_TLAST) state_next = REPORT;
      end
      REPORT: begin
        m_tvalid = 1'b1;
        if (M_AXIS_S2MM_TREADY && last_rpt) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Section routing, totals, flags and report word index.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sec_idx_reg  <= '0;
      rpt_idx_reg  <= '0;
      total_reg    <= '0;
      overflow_reg <= 1'b0;
      early_reg    <= 1'b0;
    end else if (clear_all) begin
      sec_idx_reg  <= '0;
      rpt_idx_reg  <= '0;
      total_reg    <= '0;
      overflow_reg <= 1'b0;
      early_reg    <= 1'b0;
    end else begin
      if (s_fire) begin
        total_reg <= total_reg + 32'd1;
        if (!accept_word) overflow_reg <= 1'b1;
        else if (sec_done) sec_idx_reg <= sec_idx_reg + 4'd1;
        if (S_AXIS_MM2S_TLAST && ((total_reg + 32'd1) < TOTAL_WORDS)) early_reg <= 1'b1;
      end
      if (m_tvalid && M_AXIS_S2MM_TREADY) rpt_idx_reg <= rpt_idx_reg + 4'd1;
    end
  end

  // Report word mux; contents are frozen during REPORT so each word holds until taken.
  always_comb begin
    rpt_data = '0;
    if (m_tvalid) begin
      if (last_rpt) rpt_data = {total_reg, 30'b0, overflow_reg, early_reg};
      else          rpt_data = {4'h0, rpt_idx_reg, cnt_vec[rpt_idx_reg], sum_vec[rpt_idx_reg]};
    end
  end

  assign S_AXIS_MM2S_TREADY = tready_reg;
  assign M_AXIS_S2MM_TVALID = m_tvalid;
  assign M_AXIS_S2MM_TDATA  = rpt_data;
  assign M_AXIS_S2MM_TKEEP  = m_tvalid ? {TBYTE{1'b1}} : {TBYTE{1'b0}};
  assign M_AXIS_S2MM_TLAST  = m_tvalid & last_rpt;

endmodule

// File: tb/tb_yolo_stream_loader.sv
// tb_yolo_stream_loader: drives load packets into yolo_stream_loader and checks
// every report cycle against a section-table model of the expected digests.
module tb_yolo_stream_loader;

  localparam int TOTAL = 24649;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;

  always #5 aclk = ~aclk;

  yolo_stream_loader #(.TBITS(64), .TBYTE(8)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .S_AXIS_MM2S_ACLK   (aclk),
    .M_AXIS_S2MM_ACLK   (aclk),
    .S_AXIS_MM2S_TVALID (s_tvalid),
    .S_AXIS_MM2S_TREADY (s_tready),
    .S_AXIS_MM2S_TDATA  (s_tdata),
    .S_AXIS_MM2S_TKEEP  (s_tkeep),
    .S_AXIS_MM2S_TLAST  (s_tlast),
    .M_AXIS_S2MM_TVALID (m_tvalid),
    .M_AXIS_S2MM_TREADY (m_tready),
    .M_AXIS_S2MM_TDATA  (m_tdata),
    .M_AXIS_S2MM_TKEEP  (m_tkeep),
    .M_AXIS_S2MM_TLAST  (m_tlast)
  );

  int errors = 0;
  int checks = 0;

  // Model state: section sizes, per-section counts/sums, expected report queue.
  int          sz [12] = '{384, 5, 32, 480, 32, 5120, 64, 10240, 64, 8192, 4, 32};
  int unsigned m_cnt [12];
  logic [31:0] m_sum [12];
  int          m_total;
  bit          m_ovf;
  logic [63:0] exp_q [$];
  logic [63:0] got [13];
  int          rpt_n;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Section that global word n belongs to, from the cumulative size table.
  function automatic int sec_of(input int n);
    int acc = 0;
    for (int s = 0; s < 12; s++) begin
      acc += sz[s];
      if (n < acc) return s;
    end
    return 11;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 12; s++) begin
      m_cnt[s] = 0;
      m_sum[s] = '0;
    end
    for (int i = 0; i < 13; i++) got[i] = 'x;
    m_total = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
    rpt_n = 0;
  endtask

  task automatic model_word(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] md = '0;
    int s;
    for (int b = 0; b < 8; b++) if (k[b]) md[b*8 +: 8] = d[b*8 +: 8];
    if (m_total < TOTAL) begin
      s = sec_of(m_total);
      m_cnt[s]++;
      m_sum[s] = m_sum[s] + md[63:32] + md[31:0];
    end else begin
      m_ovf = 1'b1;
    end
    m_total++;
  endtask

  task automatic model_report();
    for (int s = 0; s < 12; s++) exp_q.push_back({8'(s), 24'(m_cnt[s]), m_sum[s]});
    exp_q.push_back({32'(m_total), 30'b0, m_ovf, 1'(m_total < TOTAL)});
  endtask

  // Present one word and wait (bounded) for it to be accepted.
  task automatic put_word(input logic [63:0] d, input logic [7:0] k, input logic last, output bit ok);
    int t = 0;
    bit acc = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = last;
    while (!acc && t < 50) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      t++;
    end
    #1;
    ok = acc;
    if (acc) model_word(d, k);
    else chk("s_accept_timeout", 64'(acc), 64'd1);
  endtask

  // mode: 0 nominal ones, 1 random, 2 value 1, 3 all-ones with keep 0F.
  // rmode: 0 ready high, 1 hold ready low 10 cycles, 2 random ready.
  task automatic run_load(input int n, input int mode, input bit gaps, input int rmode);
    logic [63:0] d;
    logic [7:0]  k;
    bit ok;
    model_clear();
    m_tready = (rmode == 0);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       begin d = 64'h0000_0001_0000_0001; k = 8'hFF; end
        1:       begin d = {$urandom, $urandom}; k = 8'($urandom_range(0, 255)); end
        2:       begin d = 64'h1; k = 8'hFF; end
        default: begin d = '1; k = 8'h0F; end
      endcase
      if (gaps && $urandom_range(0, 7) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
      put_word(d, k, (i == n - 1), ok);
      if (!ok) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_report();
    @(negedge aclk);
    chk("first_tvalid_after_tlast", 64'(m_tvalid), 64'd1);
    chk("s_tready_low_in_report", 64'(s_tready), 64'd0);
    if (rmode == 1) begin
      repeat (10) @(posedge aclk);
      #1;
      chk("backpressure_no_transfer", 64'(rpt_n), 64'd0);
      m_tready = 1'b1;
    end
    for (int t = 0; t < 300 && rpt_n < 13; t++) begin
      @(posedge aclk);
      #1;
      if (rmode == 2) m_tready = 1'($urandom_range(0, 1));
    end
    chk("report_count", 64'(rpt_n), 64'd13);
    m_tready = 1'b1;
    @(negedge aclk);
    chk("load_ready_after_report", 64'(s_tready), 64'd1);
    chk("tvalid_low_after_report", 64'(m_tvalid), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  // Compare process: checks every report-side cycle against the model queue.
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_report_word: got %h, expected no word", m_tdata);
        end else begin
          chk($sformatf("report_word%0d", rpt_n), m_tdata, exp_q[0]);
          chk("report_tkeep", 64'(m_tkeep), 64'hFF);
          chk("report_tlast", 64'(m_tlast), 64'(exp_q.size() == 1));
          chk("s_tready_during_report", 64'(s_tready), 64'd0);
          if (m_tready) begin
            if (rpt_n < 13) got[rpt_n] = m_tdata;
            $display("report word %0d: data=%h last=%0d", rpt_n, m_tdata, m_tlast);
            void'(exp_q.pop_front());
            rpt_n++;
          end
        end
      end else begin
        chk("idle_tkeep", 64'(m_tkeep), 64'd0);
        chk("idle_tlast", 64'(m_tlast), 64'd0);
        if (prev_v && !prev_r) chk("tvalid_held_until_ready", 64'(m_tvalid), 64'd1);
      end
      prev_v = m_tvalid;
      prev_r = m_tready;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ecnt [12];
    bit ok;
    model_clear();
    // Reset state
    repeat (3) @(negedge aclk);
    chk("reset_s_tready", 64'(s_tready), 64'd0);
    chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset_m_tdata", m_tdata, 64'd0);
    chk("reset_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("reset_m_tlast", 64'(m_tlast), 64'd0);
    aresetn = 1'b1;
    #1 chk("tready_before_first_edge", 64'(s_tready), 64'd0);
    @(negedge aclk);
    chk("tready_after_first_edge", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;

    // Nominal load
    run_load(TOTAL, 0, 1'b0, 0);
    chk("nominal_word0", got[0], 64'h0000_0180_0000_0300);
    chk("nominal_word7", got[7], 64'h0700_2800_0000_5000);
    chk("nominal_status", got[12], 64'h0000_6049_0000_0000);

    // Early TLAST on word 400
    run_load(400, 2, 1'b1, 2);
    ecnt = '{384, 5, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int s = 0; s < 12; s++) chk($sformatf("early_count%0d", s), 64'(got[s][55:32]), 64'(ecnt[s]));
    chk("early_status", got[12], 64'h0000_0190_0000_0001);

    // TKEEP masking on the image section
    run_load(384, 3, 1'b1, 0);
    chk("tkeep_sum0", 64'(got[0][31:0]), 64'hFFFF_FE80);
    chk("tkeep_count0", 64'(got[0][55:32]), 64'd384);

    // Random data, keep, gaps and ready
    run_load(1000 + $urandom_range(0, 200), 1, 1'b1, 2);

    // Overflow with random data
    run_load(TOTAL + 3, 1, 1'b0, 2);
    chk("overflow_count11", 64'(got[11][55:32]), 64'd32);
    chk("overflow_status", got[12], 64'h0000_604C_0000_0002);

    // Reset during section 5, then a nominal load with report backpressure
    model_clear();
    for (int i = 0; i < 1200; i++) begin
      put_word(64'h0000_0001_0000_0001, 8'hFF, 1'b0, ok);
      if (!ok) break;
    end
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("midreset_s_tready", 64'(s_tready), 64'd0);
    chk("midreset_m_tvalid", 64'(m_tvalid), 64'd0);
    s_tvalid = 1'b0;
    model_clear();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    run_load(TOTAL, 0, 1'b0, 1);
    chk("after_reset_word0", got[0], 64'h0000_0180_0000_0300);
    chk("after_reset_word7", got[7], 64'h0700_2800_0000_5000);
    chk("after_reset_status", got[12], 64'h0000_6049_0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
